lea_block_byte_serializer: RTL and testbench



---
 rtl/lea_block_byte_serializer_if.sv | 22 ++
 rtl/lea_block_byte_serializer.sv | 78 +++++++
 tb/tb_lea_block_byte_serializer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lea_block_byte_serializer_if.sv
// rtl/lea_block_byte_serializer_if.sv - block-in / byte-out handshake bundle for lea_block_byte_serializer
interface lea_block_byte_serializer_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] Din;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   Dout;
    logic [3:0]   out_idx;
    logic         out_last;
    logic         busy;

    modport master (
        output in_valid, Din, out_ready,
        input  in_ready, out_valid, Dout, out_idx, out_last, busy
    );

    modport slave (
        input  in_valid, Din, out_ready,
        output in_ready, out_valid, Dout, out_idx, out_last, busy
    );
endinterface

// File: rtl/lea_block_byte_serializer.sv
// rtl/lea_block_byte_serializer.sv - 128-bit LEA block to byte stream with one-block pending buffer
// Optional build macro LEA_SER_MSB_FIRST_EN emits byte 15 first instead of byte 0.
module lea_block_byte_serializer (
    input  logic                          CLK,
    input  logic                          RST,
    lea_block_byte_serializer_if.slave    bus
);
    typedef enum logic {IDLE, STREAM} state_t;

    state_t       state_q;
    logic [127:0] active_q;
    logic [127:0] pend_q;
    logic         pend_full_q;
    logic [3:0]   cnt_q;
    logic [3:0]   cnt_d;
    logic [3:0]   idx;
    logic         accept;
    logic         byte_fire;
    logic         last_fire;

    assign bus.in_ready  = !pend_full_q && !RST;
    assign bus.out_valid = (state_q == STREAM);

    assign accept    = bus.in_valid && bus.in_ready;
    assign byte_fire = bus.out_valid && bus.out_ready;
    assign last_fire = byte_fire && (cnt_q == 4'hF);
    assign cnt_d     = cnt_q + 4'd1;

`ifdef LEA_SER_MSB_FIRST_EN
    assign idx = 4'hF - cnt_q;
`else
    assign idx = cnt_q;
`endif

    // out_idx and out_last are forced low while idle so a finished block leaves no stale marker.
    assign bus.Dout     = active_q[{idx, 3'b000} +: 8];
    assign bus.out_idx  = bus.out_valid ? idx : 4'h0;
    assign bus.out_last = bus.out_valid && (cnt_q == 4'hF);
    assign bus.busy     = bus.out_valid || pend_full_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            active_q    <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            cnt_q       <= 4'h0;
        end else if (last_fire) begin
            // A pending block has priority; otherwise a same-cycle accept reloads with no bubble.
            if (pend_full_q) begin
                active_q    <= pend_q;
                pend_full_q <= 1'b0;
                cnt_q       <= 4'h0;
                state_q     <= STREAM;
            end else if (accept) begin
                active_q <= bus.Din;
                cnt_q    <= 4'h0;
                state_q  <= STREAM;
            end else begin
                state_q <= IDLE;
            end
        end else begin
            if (byte_fire) begin
                cnt_q <= cnt_d;
            end
            if (accept) begin
                if (state_q == IDLE) begin
                    active_q <= bus.Din;
                    cnt_q    <= 4'h0;
                    state_q  <= STREAM;
                end else begin
                    pend_q      <= bus.Din;
                    pend_full_q <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_lea_block_byte_serializer.sv
// tb/tb_lea_block_byte_serializer.sv - directed self-checking bench for lea_block_byte_serializer
module tb_lea_block_byte_serializer;
    logic CLK = 1'b0;
    logic RST;
    int   tests = 0;
    int   fails = 0;

    always #5 CLK = ~CLK;

    lea_block_byte_serializer_if bus ();

    lea_block_byte_serializer dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    function automatic logic [127:0] mk(input logic [7:0] base);
        logic [127:0] v;
        for (int k = 0; k < 16; k++) v[8*k +: 8] = base + 8'(k);
        return v;
    endfunction

    // Source byte index emitted at stream position p.
    function automatic logic [3:0] pidx(input int p);
`ifdef LEA_SER_MSB_FIRST_EN
        return 4'(15 - p);
`else
        return 4'(p);
`endif
    endfunction

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        logic [15:0] got;
        RST = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.Din       = '0;
        repeat (3) step();
        got = {bus.out_valid, bus.Dout, bus.out_idx, bus.out_last, bus.busy, bus.in_ready};
        tests++;
        if (got !== 16'h0) begin
            fails++;
            $display("FAIL reset_outputs got %h expected 0000", got);
        end
        RST = 1'b0;
        step();
        tests++;
        if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
            fails++;
            $display("FAIL reset_release got %b expected 100", {bus.in_ready, bus.out_valid, bus.busy});
        end
    endtask

    task automatic test_single;
        logic [13:0] got;
        logic [13:0] exp;
        bus.Din       = 128'h0F0E0D0C0B0A09080706050403020100;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int p = 0; p < 16; p++) begin
            got = {bus.out_valid, bus.Dout, bus.out_idx, bus.out_last};
            exp = {1'b1, {4'h0, pidx(p)}, pidx(p), (p == 15)};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL single_pos%0d got %h expected %h", p, got, exp);
            end
            step();
        end
        tests++;
        if ({bus.out_valid, bus.busy, bus.out_last} !== 3'b000) begin
            fails++;
            $display("FAIL single_end got %b expected 000", {bus.out_valid, bus.busy, bus.out_last});
        end
    endtask

    task automatic test_backpressure;
        logic [13:0] exp;
        bus.Din       = 128'h0F0E0D0C0B0A09080706050403020100;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (3) step();
        bus.out_ready = 1'b0;
        exp = {1'b1, {4'h0, pidx(3)}, pidx(3), 1'b0};
        for (int c = 0; c < 6; c++) begin
            tests++;
            if ({bus.out_valid, bus.Dout, bus.out_idx, bus.out_last} !== exp) begin
                fails++;
                $display("FAIL bp_hold%0d got %h expected %h", c,
                         {bus.out_valid, bus.Dout, bus.out_idx, bus.out_last}, exp);
            end
            if (c < 5) step();
        end
        bus.out_ready = 1'b1;
        step();
        tests++;
        if ({bus.out_valid, bus.Dout, bus.out_idx} !== {1'b1, {4'h0, pidx(4)}, pidx(4)}) begin
            fails++;
            $display("FAIL bp_resume got %h expected %h", {bus.out_valid, bus.Dout, bus.out_idx},
                     {1'b1, {4'h0, pidx(4)}, pidx(4)});
        end
        repeat (12) step();
        tests++;
        if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_drain got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [127:0] a, b, c;
        a = mk(8'hA0);
        b = mk(8'hB0);
        c = mk(8'hC0);
        bus.out_ready = 1'b1;
        bus.Din       = a;
        bus.in_valid  = 1'b1;
        step();
        tests++;
        if ({bus.out_valid, bus.in_ready, bus.Dout} !== {2'b11, 8'hA0 + {4'h0, pidx(0)}}) begin
            fails++;
            $display("FAIL b2b_a0 got %h expected %h", {bus.out_valid, bus.in_ready, bus.Dout},
                     {2'b11, 8'hA0 + {4'h0, pidx(0)}});
        end
        bus.Din = b;
        step();
        bus.Din = c;
        for (int p = 1; p < 16; p++) begin
            tests++;
            if ({bus.out_valid, bus.in_ready, bus.Dout} !== {2'b10, 8'hA0 + {4'h0, pidx(p)}}) begin
                fails++;
                $display("FAIL b2b_a%0d got %h expected %h", p, {bus.out_valid, bus.in_ready, bus.Dout},
                         {2'b10, 8'hA0 + {4'h0, pidx(p)}});
            end
            step();
        end
        tests++;
        if ({bus.out_valid, bus.in_ready, bus.Dout} !== {2'b11, 8'hB0 + {4'h0, pidx(0)}}) begin
            fails++;
            $display("FAIL b2b_b0 got %h expected %h", {bus.out_valid, bus.in_ready, bus.Dout},
                     {2'b11, 8'hB0 + {4'h0, pidx(0)}});
        end
        step();
        bus.in_valid = 1'b0;
        for (int p = 1; p < 32; p++) begin
            logic [7:0] e;
            e = (p < 16) ? 8'hB0 + {4'h0, pidx(p)} : 8'hC0 + {4'h0, pidx(p - 16)};
            tests++;
            if ({bus.out_valid, bus.Dout} !== {1'b1, e}) begin
                fails++;
                $display("FAIL b2b_bc%0d got %h expected %h", p, {bus.out_valid, bus.Dout}, {1'b1, e});
            end
            step();
        end
        tests++;
        if ({bus.out_valid, bus.busy} !== 2'b00) begin
            fails++;
            $display("FAIL b2b_end got %b expected 00", {bus.out_valid, bus.busy});
        end
    endtask

    task automatic test_same_cycle;
        bus.out_ready = 1'b1;
        bus.Din       = mk(8'h50);
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (15) step();
        tests++;
        if ({bus.out_last, bus.in_ready} !== 2'b11) begin
            fails++;
            $display("FAIL same_last got %b expected 11", {bus.out_last, bus.in_ready});
        end
        bus.Din      = mk(8'h60);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        tests++;
        if ({bus.out_valid, bus.Dout, bus.out_idx} !== {1'b1, 8'h60 + {4'h0, pidx(0)}, pidx(0)}) begin
            fails++;
            $display("FAIL same_reload got %h expected %h", {bus.out_valid, bus.Dout, bus.out_idx},
                     {1'b1, 8'h60 + {4'h0, pidx(0)}, pidx(0)});
        end
        repeat (16) step();
        tests++;
        if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL same_end got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_mid_reset;
        bus.out_ready = 1'b1;
        bus.Din       = mk(8'hA0);
        bus.in_valid  = 1'b1;
        step();
        bus.Din = mk(8'hB0);
        step();
        bus.in_valid = 1'b0;
        repeat (6) step();
        tests++;
        if ({bus.busy, bus.in_ready, bus.Dout} !== {2'b10, 8'hA0 + {4'h0, pidx(7)}}) begin
            fails++;
            $display("FAIL mid_pre got %h expected %h", {bus.busy, bus.in_ready, bus.Dout},
                     {2'b10, 8'hA0 + {4'h0, pidx(7)}});
        end
        RST = 1'b1;
        step();
        tests++;
        if ({bus.out_valid, bus.busy, bus.in_ready} !== 3'b000) begin
            fails++;
            $display("FAIL mid_reset got %b expected 000", {bus.out_valid, bus.busy, bus.in_ready});
        end
        RST = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            tests++;
            if ({bus.out_valid, bus.busy} !== 2'b00) begin
                fails++;
                $display("FAIL mid_after%0d got %b expected 00", c, {bus.out_valid, bus.busy});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_same_cycle();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
